// File: rtl/imem_loader.sv
// imem_loader: streams IMEM_SZ pin bytes into imem while holding the core; optional checksum byte under IMEM_LOADER_CHECKSUM_EN
module imem_loader #(
  parameter int IMEM_SZ = 16,
  parameter int INST_W = 8,
  parameter int SYNC_STAGES = 2,
  localparam int AW = $clog2(IMEM_SZ),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              strobe_in,
  input  logic [INST_W-1:0] data_in,
  output logic              imem_we,
  output logic [AW-1:0]     imem_waddr,
  output logic [INST_W-1:0] imem_wdata,
  output logic              core_hold,
  output logic              loading,
  output logic              load_done,
  output logic              err
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {RUN, LOAD, DONE, CHK, ERR} state_t;
  logic [INST_W-1:0] csum, csum_n;
  logic req_prev;
`else
  typedef enum logic [1:0] {RUN, LOAD, DONE} state_t;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SYNC_STAGES-1:0] req_sync, stb_sync;
  logic stb_prev, req_s, stb_edge, we_n, done_n;
  assign req_s = req_sync[SYNC_STAGES-1];
  assign stb_edge = stb_sync[SYNC_STAGES-1] & ~stb_prev;
  assign core_hold = state != RUN;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign loading = state == LOAD || state == CHK;
  assign err = state == ERR;
`else
  assign loading = state == LOAD;
  assign err = 1'b0;
`endif
  // pin synchronizers; the strobe path resets high so a strobe held through reset makes no edge
  always_ff @(posedge clk) begin
    if (rst) begin
      req_sync <= '0;
      stb_sync <= '1;
      stb_prev <= 1'b1;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], load_req};
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], strobe_in};
      stb_prev <= stb_sync[SYNC_STAGES-1];
    end
  end
  // next-state logic; a load_req drop wins over a same-cycle strobe edge
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    we_n = 1'b0;
    done_n = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_n = csum;
`endif
    case (state)
      RUN: if (req_s) begin
        state_n = LOAD;
        cnt_n = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_n = '0;
`endif
      end
      LOAD: if (!req_s) state_n = RUN;
      else if (stb_edge) begin
        we_n = 1'b1;
        cnt_n = cnt + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_n = csum ^ data_in;
        if (cnt == CW'(IMEM_SZ - 1)) state_n = CHK;
`else
        if (cnt == CW'(IMEM_SZ - 1)) state_n = DONE;
`endif
      end
      DONE: if (!req_s) begin
        state_n = RUN;
        done_n = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: if (!req_s) state_n = RUN;
      else if (stb_edge) state_n = data_in == csum ? DONE : ERR;
      ERR: if (req_s && !req_prev) begin
        state_n = LOAD;
        cnt_n = '0;
        csum_n = '0;
      end
`endif
      default: state_n = RUN;
    endcase
  end
  // state, counter and registered imem write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt <= '0;
      imem_we <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      load_done <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum <= '0;
      req_prev <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      imem_we <= we_n;
      load_done <= done_n;
      if (we_n) begin
        imem_waddr <= cnt[AW-1:0];
        imem_wdata <= data_in;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum <= csum_n;
      req_prev <= req_s;
`endif
    end
  end
endmodule
